// File: rtl/trace_capture_buffer_pkg.sv
// Shared display package: trace geometry defaults and the capture FSM encoding.
// Both the capture buffer and the display path import this.
package trace_capture_buffer_pkg;

  localparam int DISP_SAMPLE_W  = 12;
  localparam int DISP_TRACE_LEN = 800;

  typedef enum logic [1:0] {
    ST_ARMED   = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FULL    = 2'd2
  } cap_state_e;

endpackage

// File: rtl/trace_dpram.sv
// Two-bank trace storage: one write port and one registered read port.
// The bank-select bit is the MSB of each address.
module trace_dpram #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic              i_wbank,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rbank,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [0:(2**(ADDR_W+1))-1];
  logic [DATA_W-1:0] r_rdata;

  // Storage itself is never reset; the owner masks stale contents.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[{i_wbank, i_waddr}] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[{i_rbank, i_raddr}];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/trace_capture_buffer.sv
// Double-buffered oscilloscope trace capture: rising-edge trigger or auto
// timeout fills the back bank, and the banks swap at the next frame start.
module trace_capture_buffer
  import trace_capture_buffer_pkg::*;
#(
  parameter int SAMPLE_W     = DISP_SAMPLE_W,
  parameter int TRACE_LEN    = DISP_TRACE_LEN,
  parameter int AUTO_TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                frame_start,
  input  logic [9:0]          pixel_x,
  output logic [SAMPLE_W-1:0] value,
  output logic                armed,
  output logic                trace_ready
);

  localparam int AW = $clog2(TRACE_LEN);
  localparam int TW = $clog2(AUTO_TIMEOUT + 1);

  cap_state_e          r_state, w_next_state;
  logic [SAMPLE_W-1:0] r_prev;
  logic [AW-1:0]       r_waddr, w_next_waddr;
  logic [TW-1:0]       r_timeout, w_next_timeout;
  logic                r_front, r_front_valid, r_rd_ok;
  logic                w_trigger, w_timeout_hit, w_we, w_swap, w_in_range;
  logic [AW-1:0]       w_raddr;
  logic [SAMPLE_W-1:0] w_rdata;

  assign w_trigger     = sample_valid && (r_prev < trig_level) && (sample_in >= trig_level);
  assign w_timeout_hit = sample_valid && (r_timeout == TW'(AUTO_TIMEOUT - 1));
  assign w_in_range    = (32'(pixel_x) < TRACE_LEN);
  assign w_raddr       = w_in_range ? AW'(pixel_x) : '0;

  // r_waddr idles at 0 while ARMED, so the starting sample lands at address 0.
  always_comb begin
    w_next_state   = r_state;
    w_next_waddr   = r_waddr;
    w_next_timeout = r_timeout;
    w_we           = 1'b0;
    w_swap         = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (w_trigger || w_timeout_hit) begin
          w_we           = 1'b1;
          w_next_waddr   = AW'(1);
          w_next_timeout = '0;
          w_next_state   = ST_CAPTURE;
        end else if (sample_valid) begin
          w_next_timeout = r_timeout + 1'b1;
        end
      end
      ST_CAPTURE: begin
        if (sample_valid) begin
          w_we = 1'b1;
          if (r_waddr == AW'(TRACE_LEN - 1)) begin
            w_next_waddr = '0;
            w_next_state = ST_FULL;
          end else begin
            w_next_waddr = r_waddr + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (frame_start) begin
          w_swap         = 1'b1;
          w_next_timeout = '0;
          w_next_state   = ST_ARMED;
        end
      end
      default: w_next_state = ST_ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_ARMED;
      r_waddr       <= '0;
      r_timeout     <= '0;
      r_prev        <= '0;
      r_front       <= 1'b0;
      r_front_valid <= 1'b0;
      r_rd_ok       <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_waddr   <= w_next_waddr;
      r_timeout <= w_next_timeout;
      r_rd_ok   <= r_front_valid && w_in_range;
      if (sample_valid) begin
        r_prev <= sample_in;
      end
      if (w_swap) begin
        r_front       <= ~r_front;
        r_front_valid <= 1'b1;
      end
    end
  end

  trace_dpram #(
    .DATA_W (SAMPLE_W),
    .ADDR_W (AW)
  ) u_dpram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_we),
    .i_wbank (~r_front),
    .i_waddr (r_waddr),
    .i_wdata (sample_in),
    .i_rbank (r_front),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // The mask is registered alongside the read so both line up with pixel_x.
  assign value       = r_rd_ok ? w_rdata : '0;
  assign armed       = (r_state == ST_ARMED);
  assign trace_ready = (r_state == ST_FULL);

endmodule

// File: tb/tb_trace_capture_buffer.sv
// Directed bench for trace_capture_buffer with a queue-based trace model
// compared against the DUT outputs on every falling clock edge.
module tb_trace_capture_buffer;

  localparam int LEN = 800;
  localparam int TMO = 4096;

  logic        clk;
  logic        rst_n;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [11:0] trig_level;
  logic        frame_start;
  logic [9:0]  pixel_x;
  logic [11:0] value;
  logic        armed;
  logic        trace_ready;

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  trace_capture_buffer #(
    .SAMPLE_W     (12),
    .TRACE_LEN    (LEN),
    .AUTO_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .trig_level   (trig_level),
    .frame_start  (frame_start),
    .pixel_x      (pixel_x),
    .value        (value),
    .armed        (armed),
    .trace_ready  (trace_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the back bank is a queue of captured samples; empty means armed,
  // full length means waiting for the swap.
  int prevM = 0;
  int lastPrev = 0;
  int timeoutM = 0;
  int backQ[$];
  int frontMem[LEN];
  bit frontValidM = 0;
  int expVal = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevM = 0;
      timeoutM = 0;
      backQ.delete();
      frontValidM = 0;
      expVal = 0;
    end else begin
      expVal = (frontValidM && int'(pixel_x) < LEN) ? frontMem[pixel_x] : 0;
      lastPrev = prevM;
      if (sample_valid) prevM = int'(sample_in);
      if (backQ.size() == 0) begin
        if (sample_valid) begin
          if ((lastPrev < int'(trig_level) && int'(sample_in) >= int'(trig_level)) ||
              timeoutM == TMO - 1) begin
            backQ.push_back(int'(sample_in));
            timeoutM = 0;
          end else begin
            timeoutM++;
          end
        end
      end else if (backQ.size() < LEN) begin
        if (sample_valid) backQ.push_back(int'(sample_in));
      end else if (frame_start) begin
        for (int k = 0; k < LEN; k++) frontMem[k] = backQ[k];
        frontValidM = 1;
        backQ.delete();
        timeoutM = 0;
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      checkOutput("value", int'(value), expVal);
      checkOutput("armed", int'(armed), (backQ.size() == 0) ? 1 : 0);
      checkOutput("trace_ready", int'(trace_ready), (backQ.size() == LEN) ? 1 : 0);
    end
  end

  // Each call drives one cycle's worth of inputs.
  task automatic applyStimulus(input logic v, input int s, input logic fs, input int px);
    @(negedge clk);
    sample_valid = v;
    sample_in    = 12'(s);
    frame_start  = fs;
    pixel_x      = 10'(px);
  endtask

  task automatic pinValue(input int px, input int lit);
    applyStimulus(1'b0, 0, 1'b0, px);
    @(posedge clk);
    #1;
    checkOutput("pinModelValue", expVal, lit);
    checkOutput("pinValue", int'(value), lit);
  endtask

  task automatic pinFlags(input int litArmed, input int litReady);
    @(posedge clk);
    #1;
    checkOutput("pinModelArmed", (backQ.size() == 0) ? 1 : 0, litArmed);
    checkOutput("pinArmed", int'(armed), litArmed);
    checkOutput("pinReady", int'(trace_ready), litReady);
  endtask

  task automatic sweep(input int lo, input int hi);
    for (int px = lo; px <= hi; px++) applyStimulus(1'b0, 0, 1'b0, px);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    sample_in = '0;
    sample_valid = 1'b0;
    trig_level = 12'd2048;
    frame_start = 1'b0;
    pixel_x = '0;
    repeat (2) @(negedge clk);
    checking = 1;
    @(posedge clk);
    #1;
    checkOutput("resetValue", int'(value), 0);
    checkOutput("resetArmed", int'(armed), 1);
    checkOutput("resetReady", int'(trace_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] blank display after reset");
    sweep(0, LEN - 1);

    $display("[TB] ramp trigger at 2048");
    for (int i = 0; i < 1320; i++) applyStimulus(1'b1, (4 * i) % 4096, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b0, 0);
    pinFlags(0, 1);
    applyStimulus(1'b0, 0, 1'b1, 0);
    pinValue(0, 2048);
    pinValue(5, 2068);
    pinValue(700, 752);
    pinValue(799, 1148);
    pinValue(800, 0);
    pinValue(1023, 0);
    sweep(0, 1023);

    $display("[TB] auto timeout on flat signal");
    for (int i = 0; i < TMO - 1; i++) applyStimulus(1'b1, 100, 1'b0, 0);
    pinFlags(1, 0);
    applyStimulus(1'b1, 100, 1'b0, 0);
    pinFlags(0, 0);
    for (int i = 0; i < LEN - 1; i++) applyStimulus(1'b1, 100, 1'b0, 0);
    pinFlags(0, 1);
    applyStimulus(1'b0, 0, 1'b1, 0);
    pinValue(10, 100);
    pinValue(900, 0);
    sweep(0, 1023);

    $display("[TB] second capture held until frame start");
    for (int i = 0; i < LEN; i++) applyStimulus(1'b1, 3000 + i, 1'b0, 0);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 50, 1'b0, i);
    pinFlags(0, 1);
    pinValue(3, 100);
    sweep(0, LEN - 1);
    applyStimulus(1'b0, 0, 1'b1, 0);
    pinValue(3, 3003);
    pinValue(799, 3799);
    sweep(0, LEN - 1);

    $display("[TB] gapped sample_valid during capture");
    for (int i = 0; i < 2 * LEN; i++) begin
      if (i % 2 == 0) applyStimulus(1'b1, 2500 + i / 2, 1'b0, 0);
      else applyStimulus(1'b0, 4095, 1'b0, 0);
    end
    pinFlags(0, 1);
    applyStimulus(1'b0, 0, 1'b1, 0);
    pinValue(1, 2501);
    pinValue(799, 3299);
    sweep(0, LEN - 1);

    $display("[TB] reset mid-capture");
    applyStimulus(1'b1, 100, 1'b0, 0);
    applyStimulus(1'b1, 2200, 1'b0, 0);
    for (int i = 1; i < 400; i++) applyStimulus(1'b1, 2200 + i, 1'b0, 0);
    applyStimulus(1'b0, 0, 1'b0, 0);
    pinFlags(0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    pinFlags(1, 0);
    checkOutput("midResetValue", int'(value), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(1'b0, 0, 1'b1, 5);
    pinValue(5, 0);
    pinFlags(1, 0);
    sweep(0, 20);

    repeat (2) @(negedge clk);
    checking = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
